// File: rtl/listing_loader.sv
// rtl/listing_loader.sv - streams a listing table into CPU memory, then releases the CPU
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, abort, mode, count load control (mode/count latched when start is accepted)
//   ent_idx -> ent_addr/data  table read port, one cycle read latency
//   mem_addr/wdata/we, ack    memory write port, we held until ack
//   cpu_hold                  CPU reset hold, released after a completed load
//   busy, done, err           status (done is a 1-cycle pulse, err is sticky)
module listing_loader #(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 8,
    parameter int                DEPTH     = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0200,
    parameter int                IDX_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              mode,
    input  logic [IDX_W:0]    count,
    output logic [IDX_W-1:0]  ent_idx,
    input  logic [ADDR_W-1:0] ent_addr,
    input  logic [DATA_W-1:0] ent_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [IDX_W:0] DEPTH_V = (IDX_W+1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, FETCH, LATCH, WRITE, DONE} state_t;

    state_t            state, state_nx;
    logic [IDX_W-1:0]  idx;
    logic              mode_r;
    logic [IDX_W:0]    count_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] data_r;
    logic              hold_r;
    logic              err_r;

    // abort in IDLE suppresses a simultaneous start
    logic start_ok;
    logic too_many;
    logic last;

    assign start_ok = (state == IDLE) && start && !abort;
    assign too_many = (count > DEPTH_V);
    assign last     = ({1'b0, idx} == (count_r - 1'b1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            mode_r  <= 1'b0;
            count_r <= '0;
            addr_r  <= '0;
            data_r  <= '0;
            hold_r  <= 1'b1;
            err_r   <= 1'b0;
        end else begin
            state <= state_nx;
            if (start_ok) begin
                mode_r  <= mode;
                count_r <= count;
                idx     <= '0;
                err_r   <= too_many;
                if (!too_many) begin
                    hold_r <= 1'b1;
                end
            end
            if (state == LATCH && !abort) begin
                data_r <= ent_data;
                // sequential address wraps modulo 2^ADDR_W by truncation
                addr_r <= mode_r ? (BASE_ADDR + ADDR_W'(idx)) : ent_addr;
            end
            if (state == WRITE && mem_ack && !abort && !last) begin
                idx <= idx + 1'b1;
            end
            if (state == DONE && !abort) begin
                hold_r <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start_ok && !too_many) begin
                    state_nx = (count == '0) ? DONE : FETCH;
                end
            end
            FETCH:   state_nx = LATCH;
            LATCH:   state_nx = WRITE;
            WRITE: begin
                if (mem_ack) begin
                    state_nx = last ? DONE : FETCH;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (state != IDLE && abort) begin
            state_nx = IDLE;
        end
    end

    always_comb begin
        ent_idx   = idx;
        mem_addr  = addr_r;
        mem_wdata = data_r;
        mem_we    = (state == WRITE);
        busy      = (state == FETCH) || (state == LATCH) || (state == WRITE);
        done      = (state == DONE) && !abort;
        cpu_hold  = hold_r;
        err       = err_r;
    end

endmodule
